// File: rtl/z80_io_responder_pkg.sv
// Shared types and constants for the Z80 I/O responder: FSM states,
// register offsets and STATUS bit positions.
package z80_io_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAITST = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_VECTOR = 2'd3;

    localparam int STAT_RX_FULL  = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_CNT_LSB  = 3;
    localparam int STAT_OVERFLOW = 7;

    function automatic logic [7:0] pack_status(
        input logic       rx_full,
        input logic       tx_full,
        input logic       tx_empty,
        input logic [3:0] tx_count,
        input logic       overflow
    );
        logic [7:0] s;
        s                      = 8'h00;
        s[STAT_RX_FULL]        = rx_full;
        s[STAT_TX_FULL]        = tx_full;
        s[STAT_TX_EMPTY]       = tx_empty;
        s[STAT_CNT_LSB +: 4]   = tx_count;
        s[STAT_OVERFLOW]       = overflow;
        return s;
    endfunction

endpackage

// File: rtl/z80_io_responder_if.sv
// Z80 CPU bus as seen by the I/O responder; the CPU side is the master.
interface z80_io_responder_if;
    logic [15:0] ADDR;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        WR;
    logic        MREQ;
    logic        IORQ;
    logic        M1;
    logic        WAIT;
    logic        INT;

    modport master (
        output ADDR, DO, WR, MREQ, IORQ, M1,
        input  DI, WAIT, INT
    );

    modport slave (
        input  ADDR, DO, WR, MREQ, IORQ, M1,
        output DI, WAIT, INT
    );
endinterface

// File: rtl/z80_io_fifo.sv
// Byte FIFO for the TX path. A push into a full FIFO is dropped even when a
// pop happens in the same cycle; the caller flags that as overflow.
module z80_io_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O-mapped peripheral: four ports (DATA/STATUS/CTRL/VECTOR), inserted
// wait states, a TX FIFO, an RX holding register and a vectored interrupt.
module z80_io_responder
    import z80_io_responder_pkg::*;
#(
    parameter logic [7:0] PORT_BASE   = 8'h40,
    parameter int         WAIT_CYCLES = 2,
    parameter int         FIFO_DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    z80_io_responder_if.slave cpu,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t        state_r;
    logic [3:0]    wait_cnt_r;
    logic [1:0]    off_r;
    logic          ack_r;
    logic          block_r;
    logic [7:0]    di_r;
    logic          rx_full_r;
    logic [7:0]    rx_data_r;
    logic          ie_r;
    logic          overflow_r;
    logic [7:0]    vector_r;
    logic          int_r;

    logic [7:0]    offset_s;
    logic          in_range_s;
    logic          start_io_s;
    logic          start_ack_s;
    logic          do_write_s;
    logic          do_read_s;
    logic          push_s;
    logic          pop_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic [CW-1:0] tx_count_s;
    logic [7:0]    rd_data_s;
    logic          unused_ok_s;

    assign unused_ok_s = &{1'b0, cpu.ADDR[15:8]};

    assign offset_s    = cpu.ADDR[7:0] - PORT_BASE;
    assign in_range_s  = (offset_s < 8'd4);
    assign start_io_s  = cpu.IORQ & ~cpu.MREQ & ~cpu.M1 & in_range_s & ~block_r;
    assign start_ack_s = cpu.IORQ & cpu.M1 & int_r & ~block_r;

    // Register side effects are confined to the single ACCESS cycle.
    assign do_write_s  = (state_r == ST_ACCESS) & ~ack_r & cpu.WR;
    assign do_read_s   = (state_r == ST_ACCESS) & ~ack_r & ~cpu.WR;
    assign push_s      = do_write_s & (off_r == OFF_DATA);
    assign pop_s       = TX_VALID & TX_READY;

    assign cpu.WAIT    = (state_r == ST_WAITST) | (state_r == ST_ACCESS);
    assign cpu.DI      = di_r;
    assign cpu.INT     = int_r;
    assign TX_VALID    = ~tx_empty_s;
    assign RX_READY    = ~rx_full_r;

    z80_io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push_s),
        .push_data (cpu.DO),
        .pop       (pop_s),
        .head      (TX_DATA),
        .full      (tx_full_s),
        .empty     (tx_empty_s),
        .count     (tx_count_s)
    );

    // Read-data mux for the latched port offset.
    always_comb begin
        rd_data_s = 8'h00;
        case (off_r)
            OFF_DATA:   rd_data_s = rx_full_r ? rx_data_r : 8'h00;
            OFF_STATUS: rd_data_s = pack_status(rx_full_r, tx_full_s, tx_empty_s,
                                                4'(tx_count_s), overflow_r);
            OFF_CTRL:   rd_data_s = {7'b0000000, ie_r};
            OFF_VECTOR: rd_data_s = vector_r;
            default:    rd_data_s = 8'h00;
        endcase
    end

    // Bus-cycle FSM; block_r keeps a cycle interrupted by reset from restarting.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            off_r      <= 2'd0;
            ack_r      <= 1'b0;
            block_r    <= 1'b1;
            di_r       <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    di_r <= 8'h00;
                    if (!cpu.IORQ) begin
                        block_r <= 1'b0;
                    end
                    if (start_io_s || start_ack_s) begin
                        off_r      <= offset_s[1:0];
                        ack_r      <= start_ack_s;
                        wait_cnt_r <= 4'd0;
                        state_r    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAITST;
                    end
                end
                ST_WAITST: begin
                    if (!cpu.IORQ) begin
                        state_r <= ST_IDLE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (ack_r) begin
                        di_r <= vector_r;
                    end else if (cpu.WR) begin
                        di_r <= 8'h00;
                    end else begin
                        di_r <= rd_data_s;
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (!cpu.IORQ) begin
                        di_r    <= 8'h00;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    di_r    <= 8'h00;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Peripheral registers, RX holding register and interrupt line.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_full_r  <= 1'b0;
            rx_data_r  <= 8'h00;
            ie_r       <= 1'b0;
            overflow_r <= 1'b0;
            vector_r   <= 8'hFF;
            int_r      <= 1'b0;
        end else begin
            int_r <= ie_r & rx_full_r;
            if (RX_VALID && !rx_full_r) begin
                rx_full_r <= 1'b1;
                rx_data_r <= RX_DATA;
            end else if (do_read_s && (off_r == OFF_DATA)) begin
                rx_full_r <= 1'b0;
            end
            if (push_s && tx_full_s) begin
                overflow_r <= 1'b1;
            end else if (do_read_s && (off_r == OFF_STATUS)) begin
                overflow_r <= 1'b0;
            end
            if (do_write_s && (off_r == OFF_CTRL)) begin
                ie_r <= cpu.DO[0];
            end
            if (do_write_s && (off_r == OFF_VECTOR)) begin
                vector_r <= cpu.DO;
            end
        end
    end

endmodule

// File: doc/z80_io_responder.md
Z80_IO_RESPONDER -- requirements
Module: z80_io_responder

Interface
REQ-001 Parameters SHALL be: PORT_BASE, default 8'h40, I/O base port (ADDR[7:0]); WAIT_CYCLES, default 2, wait states per access (0..15); FIFO_DEPTH, default 8, TX FIFO entries (power of 2).
REQ-002 Ports SHALL be, one per line:
CLK  in  1  single clock, rising edge
RESET  in  1  synchronous, active-high
ADDR  in  16  CPU address; only [7:0] decoded
DO  in  8  CPU write data
DI  out  8  read data to CPU
WR  in  1  write strobe, active-high
MREQ  in  1  memory request, active-high (ignored)
IORQ  in  1  I/O request, active-high
M1  in  1  opcode fetch / interrupt-ack qualifier
WAIT  out  1  stall request to CPU, active-high
INT  out  1  interrupt request, active-high, level
TX_DATA  out  8  FIFO head byte
TX_VALID  out  1  FIFO non-empty
TX_READY  in  1  local consumer pops when TX_VALID & TX_READY
RX_DATA  in  8  inbound byte
RX_VALID  in  1  inbound byte offered
RX_READY  out  1  RX holding register empty
REQ-003 Clock SHALL be CLK; reset SHALL be RESET, synchronous, active-high; all state changes on the rising edge of CLK.

Function
REQ-004 Register map (offset from PORT_BASE) SHALL be: +0 DATA (write pushes TX FIFO; read returns RX byte and empties register); +1 STATUS (read-only: [0] rx_full, [1] tx_full, [2] tx_empty, [6:3] tx_count, [7] overflow); +2 CTRL ([0] IE, rest read 0); +3 VECTOR (read/write).
REQ-005 An access SHALL start when IORQ=1, M1=0 and ADDR[7:0] is in PORT_BASE..PORT_BASE+3 while in IDLE; an interrupt-ack SHALL start when IORQ=1 and M1=1 and INT=1.
REQ-006 FSM SHALL have states IDLE, WAITST, ACCESS, DONE: IDLE->WAITST on start (->ACCESS if WAIT_CYCLES=0); WAITST counts WAIT_CYCLES cycles then ->ACCESS; ACCESS->DONE after exactly one cycle; DONE->IDLE when IORQ=0.
REQ-007 WAIT SHALL be a decode of registered state: 1 in WAITST and ACCESS, 0 otherwise.
REQ-008 The register side effect SHALL occur only in the single ACCESS cycle, using WR to select write/read; DI SHALL load read data there, hold it through DONE, and be 8'h00 otherwise.
REQ-009 Interrupt-ack SHALL return VECTOR on DI with no side effects.
REQ-010 IORQ falling in WAITST SHALL abort to IDLE with no side effect.
REQ-011 INT SHALL equal IE & rx_full, registered.
REQ-012 RX_READY SHALL equal !rx_full; RX_VALID & RX_READY SHALL load RX_DATA and set rx_full next cycle.
REQ-013 DATA write when TX FIFO full SHALL drop the byte and set overflow; STATUS read SHALL clear overflow after returning it.
REQ-014 DATA read when rx_full=0 SHALL return 8'h00 with no effect.
REQ-015 Simultaneous push and pop SHALL both occur, count unchanged; fullness for push SHALL be judged on count before the pop.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; tx_count SHALL saturate-free range 0..FIFO_DEPTH.
REQ-017 MREQ cycles and out-of-range ports SHALL be ignored (WAIT stays 0).

Reset
REQ-018 RESET SHALL force: state IDLE, WAIT=0, INT=0, DI=8'h00, FIFO empty (TX_VALID=0), rx_full=0 (RX_READY=1), IE=0, overflow=0, VECTOR=8'hFF.
REQ-019 RESET mid-access SHALL abandon the access with no side effect; the CPU cycle SHALL then be ignored until IORQ returns to 0.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, register offset constants and STATUS bit positions.
REQ-021 The TX FIFO SHALL be one sub-module, z80_io_fifo (push/pop/full/empty/count).

Verification
REQ-022 Write 8'hA5 to port 8'h40, WAIT_CYCLES=2 -> WAIT high 3 cycles, TX_DATA=8'hA5, TX_VALID=1, STATUS=8'h08|... tx_count=1.
REQ-023 Nine writes with TX_READY=0 -> 9th dropped, STATUS[7]=1, [1]=1; second STATUS read shows [7]=0.
REQ-024 RX_DATA=8'h3C pulsed, IE=1 -> INT=1; ack cycle (M1=1, IORQ=1) with VECTOR=8'h20 -> DI=8'h20; read DATA -> 8'h3C, INT falls, RX_READY=1.
REQ-025 IORQ dropped during WAITST on DATA write -> no FIFO push, FSM IDLE.
REQ-026 RESET asserted in ACCESS of a write -> no push, all outputs at REQ-018 values, VECTOR reads 8'hFF.
REQ-027 Push and pop same cycle at count=8 -> push dropped, count 7, overflow set.
